// File: rtl/uart_sort_cpu.sv
// Loads NUM_WORDS words over UART RX, bubble-sorts them (one compare/swap per cycle), dumps them on TX.
// Sort time shown in hex on a scanned 4-digit display; RX/TX are fixed-rate 8N1 with no flow control.
module uart_sort_cpu #(
   parameter int CLKS_PER_BIT = 5,
   parameter int NUM_WORDS    = 25,
   parameter int SCAN_DIV     = 4
) (
   input  logic        sysclk,
   input  logic        reset,
   output logic [11:0] digi,
   output logic [7:0]  LED,
   input  logic        mem2uart,
   output logic        Tx_Serial,
   input  logic        Rx_Serial
);
   localparam int IDX_W     = $clog2(NUM_WORDS);
   localparam int BYTE_W    = IDX_W + 2;
   localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
   localparam int NUM_BYTES = 4 * NUM_WORDS;

   typedef enum logic [2:0] {
      S_LOAD = 3'd0, S_SORT = 3'd1, S_DONE = 3'd2, S_TX = 3'd3, S_SENT = 3'd4
   } state_t;
   state_t state, state_nxt;

   logic [31:0]      mem [NUM_WORDS];
   logic [31:0]      cycle_cnt;
   logic [4:0]       wcnt;
   logic [1:0]       byte_cnt;
   logic             rx_s1, rx_s2, rx_s3, rx_busy, byte_vld;
   logic [3:0]       rx_bit;
   logic [CNT_W-1:0] rx_cnt, tx_cnt;
   logic [7:0]       rx_shift, tx_shift, tx_byte;
   logic [IDX_W-1:0] sort_idx, sort_pass;
   logic             sort_swapped, do_swap, sort_last, sort_exit, ld, ld_last;
   logic [BYTE_W-1:0] tx_idx;
   logic [3:0]       tx_left;
   logic [31:0]      tx_word;
   logic             tx_line, tx_frame_end, tx_more, tx_load, tx_finish;
   logic [SCAN_DIV+1:0] scan_cnt;
   logic [1:0]       digit;
   logic [3:0]       nibble;
   logic [7:0]       seg;

   // RX: rx_bit 0 = start, 1..8 = data, 9 = stop
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         rx_busy  <= 1'b0;
         rx_bit   <= '0;
         rx_cnt   <= '0;
         rx_shift <= '0;
         byte_vld <= 1'b0;
      end else begin
         rx_s1    <= Rx_Serial;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         byte_vld <= 1'b0;
         if (!rx_busy) begin
            if (rx_s3 && !rx_s2) begin
               rx_busy <= 1'b1;
               rx_bit  <= 4'd0;
               rx_cnt  <= CNT_W'(1);
            end
         end else if (rx_bit == 4'd0) begin
            if (rx_cnt == CNT_W'(CLKS_PER_BIT / 2)) begin
               rx_busy <= !rx_s2;
               rx_bit  <= 4'd1;
               rx_cnt  <= CNT_W'(1);
            end else begin
               rx_cnt <= rx_cnt + 1'b1;
            end
         end else if (rx_cnt == CNT_W'(CLKS_PER_BIT)) begin
            rx_cnt <= CNT_W'(1);
            if (rx_bit == 4'd9) begin
               rx_busy  <= 1'b0;
               byte_vld <= rx_s2;
            end else begin
               rx_shift <= {rx_s2, rx_shift[7:1]};
               rx_bit   <= rx_bit + 1'b1;
            end
         end else begin
            rx_cnt <= rx_cnt + 1'b1;
         end
      end
   end

   assign ld        = byte_vld && (state == S_LOAD);
   assign ld_last   = ld && (byte_cnt == 2'd3) && (wcnt == 5'(NUM_WORDS - 1));
   assign do_swap   = mem[sort_idx] > mem[sort_idx + 1'b1];
   assign sort_last = sort_idx == (IDX_W'(NUM_WORDS - 2) - sort_pass);
   assign sort_exit = sort_last && (!(sort_swapped || do_swap) || sort_pass == IDX_W'(NUM_WORDS - 2));

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) state <= S_LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_LOAD:  if (ld_last)   state_nxt = S_SORT;
         S_SORT:  if (sort_exit) state_nxt = S_DONE;
         S_DONE:  if (mem2uart)  state_nxt = S_TX;
         S_TX:    if (tx_finish) state_nxt = S_SENT;
         default: state_nxt = state;
      endcase
   end

   // Word packing shifts bytes in from the right, so the first byte lands in [31:24]
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NUM_WORDS; k++) mem[k] <= '0;
         wcnt         <= '0;
         byte_cnt     <= '0;
         cycle_cnt    <= '0;
         sort_idx     <= '0;
         sort_pass    <= '0;
         sort_swapped <= 1'b0;
      end else begin
         if (ld) begin
            mem[wcnt] <= {mem[wcnt][23:0], rx_shift};
            byte_cnt  <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) wcnt <= wcnt + 1'b1;
         end
         if (state == S_SORT) begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (do_swap) begin
               mem[sort_idx]        <= mem[sort_idx + 1'b1];
               mem[sort_idx + 1'b1] <= mem[sort_idx];
            end
            if (sort_last) begin
               sort_idx     <= '0;
               sort_pass    <= sort_pass + 1'b1;
               sort_swapped <= 1'b0;
            end else begin
               sort_idx     <= sort_idx + 1'b1;
               sort_swapped <= sort_swapped | do_swap;
            end
         end
      end
   end

   // TX: tx_left counts bit slots remaining in the current frame (start + 8 data + stop)
   assign tx_word      = mem[tx_idx[BYTE_W-1:2]];
   assign tx_frame_end = (tx_left == 4'd0) || (tx_cnt == CNT_W'(CLKS_PER_BIT) && tx_left == 4'd1);
   assign tx_more      = tx_idx != BYTE_W'(NUM_BYTES);
   assign tx_load      = (state == S_TX) && tx_frame_end && tx_more;
   assign tx_finish    = (state == S_TX) && tx_frame_end && !tx_more;

   always_comb begin
      tx_byte = tx_word[7:0];
      case (tx_idx[1:0])
         2'd0:    tx_byte = tx_word[31:24];
         2'd1:    tx_byte = tx_word[23:16];
         2'd2:    tx_byte = tx_word[15:8];
         default: tx_byte = tx_word[7:0];
      endcase
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         tx_line  <= 1'b1;
         tx_idx   <= '0;
         tx_left  <= '0;
         tx_cnt   <= '0;
         tx_shift <= '0;
      end else if (tx_load) begin
         tx_line  <= 1'b0;
         tx_shift <= tx_byte;
         tx_left  <= 4'd10;
         tx_cnt   <= CNT_W'(1);
         tx_idx   <= tx_idx + 1'b1;
      end else if (state == S_TX && tx_left != 4'd0) begin
         if (tx_cnt == CNT_W'(CLKS_PER_BIT)) begin
            // ones shifted in behind the data become the stop bit
            tx_cnt   <= CNT_W'(1);
            tx_left  <= tx_left - 1'b1;
            tx_line  <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[7:1]};
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) scan_cnt <= '0;
      else        scan_cnt <= scan_cnt + 1'b1;
   end

   assign digit = scan_cnt[SCAN_DIV+1:SCAN_DIV];

   always_comb begin
      nibble = cycle_cnt[3:0];
      case (digit)
         2'd1:    nibble = cycle_cnt[7:4];
         2'd2:    nibble = cycle_cnt[11:8];
         2'd3:    nibble = cycle_cnt[15:12];
         default: nibble = cycle_cnt[3:0];
      endcase
   end

   always_comb begin
      seg = 8'hFF;
      case (nibble)
         4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  default: seg = 8'h8E;
      endcase
   end

   assign digi      = {~(4'b0001 << digit), seg};
   assign LED       = {wcnt, state};
   assign Tx_Serial = tx_line;
endmodule

// File: tb/tb_uart_sort_cpu.sv
// Directed bench for uart_sort_cpu: load/sort/display/dump flows with a TX byte scoreboard.
module tb_uart_sort_cpu;
   localparam int CPB    = 5;
   localparam int CLK_NS = 10;
   localparam int BIT_NS = CPB * CLK_NS;

   logic        sysclk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] digi;
   logic [7:0]  LED;
   logic        mem2uart = 1'b0;
   logic        Tx_Serial;
   logic        Rx_Serial = 1'b1;

   int          n_checks = 0;
   int          n_fail = 0;
   int          rcv_cnt = 0;
   logic [7:0]  exp_q [$];

   uart_sort_cpu #(.CLKS_PER_BIT(CPB), .NUM_WORDS(25), .SCAN_DIV(4)) dut (
      .sysclk(sysclk), .reset(reset), .digi(digi), .LED(LED),
      .mem2uart(mem2uart), .Tx_Serial(Tx_Serial), .Rx_Serial(Rx_Serial)
   );

   always #(CLK_NS / 2) sysclk = ~sysclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      reset = 1'b0;
      repeat (3) @(negedge sysclk);
      reset = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      Rx_Serial = 1'b0;
      repeat (CPB) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
         Rx_Serial = b[i];
         repeat (CPB) @(negedge sysclk);
      end
      Rx_Serial = stop;
      repeat (CPB) @(negedge sysclk);
      Rx_Serial = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
   endtask

   task automatic wait_state(input logic [2:0] s, input int max_cyc);
      int n = 0;
      while (LED[2:0] !== s && n < max_cyc) begin
         @(negedge sysclk);
         n++;
      end
      check("wait_state", {29'd0, LED[2:0]}, {29'd0, s});
   endtask

   task automatic check_digit(input int k, input logic [7:0] seg_exp);
      logic [3:0] an;
      int n = 0;
      an = ~(4'b0001 << k);
      while (digi[11:8] !== an && n < 200) begin
         @(negedge sysclk);
         n++;
      end
      check($sformatf("digit%0d_anode", k), {28'd0, digi[11:8]}, {28'd0, an});
      check($sformatf("digit%0d_seg", k), {24'd0, digi[7:0]}, {24'd0, seg_exp});
   endtask

   // TX monitor: decodes frames by mid-bit sampling and scores them against exp_q
   initial begin : monitor
      logic [7:0] b;
      logic       stop_b, abort;
      forever begin
         @(negedge Tx_Serial);
         abort = !reset;
         #(BIT_NS / 2 + 2);
         abort = abort | !reset | Tx_Serial;
         for (int i = 0; i < 8; i++) begin
            #(BIT_NS);
            b[i]  = Tx_Serial;
            abort = abort | !reset;
         end
         #(BIT_NS);
         stop_b = Tx_Serial;
         abort  = abort | !reset;
         if (!abort) begin
            rcv_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL tx_unexpected: got byte %h, expected none", b);
            end else begin
               check("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
            end
            check("tx_stop", {31'd0, stop_b}, 32'd1);
         end
      end
   end

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      #2 reset = 1'b0;
      // Reset values and digit scan order
      do_reset();
      check("rst_led", {24'd0, LED}, 32'h00);
      check("rst_tx", {31'd0, Tx_Serial}, 32'd1);
      check("rst_digi", {20'd0, digi}, 32'hEC0);
      repeat (8) @(negedge sysclk);
      check("scan0", {20'd0, digi}, 32'hEC0);
      repeat (16) @(negedge sysclk);
      check("scan1", {20'd0, digi}, 32'hDC0);
      repeat (16) @(negedge sysclk);
      check("scan2", {20'd0, digi}, 32'hBC0);
      repeat (16) @(negedge sysclk);
      check("scan3", {20'd0, digi}, 32'h7C0);
      repeat (16) @(negedge sysclk);
      check("scan_wrap", {20'd0, digi}, 32'hEC0);

      // Reverse-ordered words 25..1 with a bad-stop frame inside the first word
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h5A, 1'b0);
      repeat (2 * CPB) @(negedge sysclk);
      check("bad_stop_led", {24'd0, LED}, 32'h00);
      send_byte(8'h19, 1'b1);
      repeat (3) @(negedge sysclk);
      check("first_word_led", {24'd0, LED}, 32'h08);
      for (int v = 24; v >= 1; v--) send_word(32'(v));
      repeat (3) @(negedge sysclk);
      check("rev_sort_led", {24'd0, LED}, 32'hC9);
      wait_state(3'd2, 1000);
      check("rev_done_led", {24'd0, LED}, 32'hCA);
      check_digit(0, 8'hC6);
      check_digit(1, 8'hA4);
      check_digit(2, 8'hF9);
      check_digit(3, 8'hC0);
      rcv_cnt = 0;
      for (int v = 1; v <= 25; v++) push_word(32'(v));
      mem2uart = 1'b1;
      wait_state(3'd4, 20000);
      check("rev_sent_led", {24'd0, LED}, 32'hCC);
      repeat (20) @(negedge sysclk);
      mem2uart = 1'b0;
      check("rev_tx_count", 32'(rcv_cnt), 32'd100);
      check("rev_q_empty", 32'(exp_q.size()), 32'd0);

      // Pre-sorted input with mem2uart held from the start of LOAD
      do_reset();
      check("rst2_led", {24'd0, LED}, 32'h00);
      check("rst2_digi", {20'd0, digi}, 32'hEC0);
      rcv_cnt = 0;
      mem2uart = 1'b1;
      for (int v = 1; v <= 25; v++) begin
         push_word(32'(v));
         send_word(32'(v));
      end
      check("sorted_no_early_tx", 32'(rcv_cnt), 32'd0);
      repeat (3) @(negedge sysclk);
      check("sorted_sort_led", {24'd0, LED}, 32'hC9);
      check("sorted_tx_idle", {31'd0, Tx_Serial}, 32'd1);
      wait_state(3'd3, 200);
      wait_state(3'd4, 20000);
      check("sorted_sent_led", {24'd0, LED}, 32'hCC);
      check_digit(0, 8'h80);
      check_digit(1, 8'hF9);
      check_digit(2, 8'hC0);
      repeat (300) @(negedge sysclk);
      check("sorted_tx_count", 32'(rcv_cnt), 32'd100);
      check("sorted_q_empty", 32'(exp_q.size()), 32'd0);
      check("sent_tx_idle", {31'd0, Tx_Serial}, 32'd1);
      check("sent_stays", {24'd0, LED}, 32'hCC);

      // Multi-byte words, then reset in the middle of the dump
      do_reset();
      rcv_cnt = 0;
      for (int j = 1; j <= 25; j++) push_word({8'(j), 8'hA5, 8'(25 - j), 8'h3C});
      for (int i = 0; i < 25; i++) send_word({8'(25 - i), 8'hA5, 8'(i), 8'h3C});
      wait_state(3'd3, 1000);
      begin
         int n = 0;
         while (rcv_cnt < 6 && n < 2000) begin
            @(negedge sysclk);
            n++;
         end
         check("mid_tx_bytes", 32'(rcv_cnt), 32'd6);
         n = 0;
         while (Tx_Serial !== 1'b0 && n < 200) begin
            @(negedge sysclk);
            n++;
         end
      end
      check("mid_tx_line_low", {31'd0, Tx_Serial}, 32'd0);
      reset = 1'b0;
      #1;
      check("mid_rst_tx", {31'd0, Tx_Serial}, 32'd1);
      check("mid_rst_led", {24'd0, LED}, 32'h00);
      check("mid_rst_digi", {20'd0, digi}, 32'hEC0);
      repeat (10) @(negedge sysclk);
      exp_q.delete();
      reset = 1'b1;
      repeat (100) @(negedge sysclk);
      check("post_rst_led", {24'd0, LED}, 32'h00);
      check("post_rst_tx", {31'd0, Tx_Serial}, 32'd1);
      check("post_rst_bytes", 32'(rcv_cnt), 32'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
